// File: rtl/acc_sched_if.sv
// acc_sched_if: array-side input stream and unified-buffer-side drain stream.
interface acc_sched_if #(parameter int WIDTH = 32);
    logic in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] in_data, out_data;
    modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/acc_sched.sv
// acc_sched: accumulator-buffer sequencer; fills rows (overwrite or add) then drains them in order.
module acc_sched #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int ADDR_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [ADDR_W:0] num_rows,
    input  logic            acc_mode,
    input  logic            clear,
    acc_sched_if.slave      bus,
    output logic            busy,
    output logic            done,
    output logic            cfg_err,
    output logic            overflow
);
    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;
    state_t state, next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0] rows, last_row;
    logic mode, legal, wr_last, rd_last, wr_fire, rd_fire;
    logic [WIDTH:0] sum;
    assign legal    = num_rows != '0 && num_rows <= (ADDR_W+1)'(DEPTH);
    assign last_row = rows - (ADDR_W+1)'(1);
    assign wr_last  = {1'b0, wr_ptr} == last_row;
    assign rd_last  = {1'b0, rd_ptr} == last_row;
    assign wr_fire  = state == FILL && bus.in_valid;
    assign rd_fire  = state == DRAIN && bus.out_ready;
    assign sum      = {1'b0, mem[wr_ptr]} + {1'b0, bus.in_data};
    assign bus.in_ready  = state == FILL;
    assign bus.out_valid = state == DRAIN;
    assign bus.out_data  = state == DRAIN ? mem[rd_ptr] : '0;
    assign busy = state != IDLE;
    assign done = state == DONE;
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start && legal ? FILL : IDLE;
            FILL:    next = wr_fire && wr_last ? DRAIN : FILL;
            DRAIN:   next = rd_fire && rd_last ? DONE : DRAIN;
            default: next = IDLE;
        endcase
    end
    // Rows persist across jobs so a later accumulate job can add onto them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rows     <= '0;
            mode     <= 1'b0;
            cfg_err  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            cfg_err <= state == IDLE && start && !legal;
            if (state == IDLE && start && legal) begin
                rows     <= num_rows;
                mode     <= acc_mode;
                wr_ptr   <= '0;
                overflow <= 1'b0;
            end else if (state == IDLE && clear) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end
            if (wr_fire) begin
                mem[wr_ptr] <= mode ? sum[WIDTH-1:0] : bus.in_data;
                overflow    <= overflow | (mode & sum[WIDTH]);
                wr_ptr      <= wr_last ? wr_ptr : wr_ptr + ADDR_W'(1);
                rd_ptr      <= '0;
            end
            if (rd_fire) rd_ptr <= rd_last ? rd_ptr : rd_ptr + ADDR_W'(1);
        end
    end
endmodule

// File: tb/tb_acc_sched.sv
// tb_acc_sched: table-driven jobs plus hand sequences for stalls, bad configs, clear and reset.
module tb_acc_sched;
    typedef struct {
        logic [2:0]  rows;
        logic        mode;
        logic [31:0] d [4];
        logic [31:0] e [4];
        logic        ovf;
    } job_t;
    logic clk = 0, reset = 0, start = 0, acc_mode = 0, clear = 0;
    logic [2:0] num_rows = 0;
    logic busy, done, cfg_err, overflow;
    int total = 0, bad = 0, done_cnt = 0, err_cnt = 0, exp_done = 0;
    job_t jobs [8];
    acc_sched_if #(.WIDTH(32)) bus();
    acc_sched dut (
        .clk(clk), .reset(reset), .start(start), .num_rows(num_rows), .acc_mode(acc_mode),
        .clear(clear), .bus(bus), .busy(busy), .done(done), .cfg_err(cfg_err), .overflow(overflow)
    );
    always #5 clk = ~clk;
    always begin
        @(posedge clk);
        #2;
        done_cnt += int'(done);
        err_cnt += int'(cfg_err);
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic run_job(input job_t j);
        start = 1; num_rows = j.rows; acc_mode = j.mode;
        @(negedge clk);
        start = 0;
        chk("busy_fill", busy, 1);
        chk("in_ready", bus.in_ready, 1);
        for (int i = 0; i < j.rows; i++) begin
            bus.in_valid = 1; bus.in_data = j.d[i];
            @(negedge clk);
        end
        bus.in_valid = 0;
        chk("drain_latency", bus.out_valid, 1);
        bus.out_ready = 1;
        for (int i = 0; i < j.rows; i++) begin
            chk($sformatf("out_data[%0d]", i), bus.out_data, j.e[i]);
            @(negedge clk);
        end
        bus.out_ready = 0;
        chk("done_pulse", done, 1);
        exp_done++;
        @(negedge clk);
        chk("done_once", done, 0);
        chk("busy_idle", busy, 0);
        chk("overflow", overflow, j.ovf);
        chk("done_cnt", done_cnt, exp_done);
    endtask
    function automatic job_t mk(input logic [2:0] r, input logic m, input logic [31:0] d0, d1, d2, d3,
                                input logic [31:0] e0, e1, e2, e3, input logic o);
        job_t j;
        j.rows = r; j.mode = m; j.ovf = o;
        j.d[0] = d0; j.d[1] = d1; j.d[2] = d2; j.d[3] = d3;
        j.e[0] = e0; j.e[1] = e1; j.e[2] = e2; j.e[3] = e3;
        return j;
    endfunction
    initial begin
        logic [31:0] bp_exp [3];
        logic bp_rdy [6];
        int hs;
        jobs[0] = mk(2, 0, 7, 9, 0, 0, 7, 9, 0, 0, 0);
        jobs[1] = mk(4, 0, 1, 2, 3, 4, 1, 2, 3, 4, 0);
        jobs[2] = mk(4, 1, 10, 20, 30, 40, 11, 22, 33, 44, 0);
        jobs[3] = mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        jobs[4] = mk(1, 1, 2, 0, 0, 0, 1, 0, 0, 0, 1);
        jobs[5] = mk(4, 1, 0, 0, 0, 0, 1, 22, 33, 44, 0);
        jobs[6] = mk(3, 0, 5, 6, 7, 0, 5, 6, 7, 0, 0);
        jobs[7] = mk(4, 1, 1, 1, 1, 1, 6, 7, 8, 45, 0);
        bp_exp = '{0, 5, 0};
        bp_rdy = '{0, 1, 0, 0, 1, 1};
        bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_data", bus.out_data, 0);
        reset = 1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) run_job(jobs[k]);
        // Backpressure with zero-valued samples.
        start = 1; num_rows = 3; acc_mode = 0;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1; bus.in_data = bp_exp[i];
            @(negedge clk);
        end
        bus.in_valid = 0;
        hs = 0;
        for (int k = 0; k < 6; k++) begin
            bus.out_ready = bp_rdy[k];
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_data", bus.out_data, bp_exp[hs]);
            chk("bp_no_done", done, 0);
            if (bp_rdy[k]) hs++;
            @(negedge clk);
        end
        bus.out_ready = 0;
        chk("bp_handshakes", hs, 3);
        chk("bp_done", done, 1);
        exp_done++;
        @(negedge clk);
        chk("bp_done_cnt", done_cnt, exp_done);
        // Rejected configurations.
        start = 1; num_rows = 0;
        @(negedge clk);
        start = 0;
        chk("cfg0_err", cfg_err, 1);
        chk("cfg0_busy", busy, 0);
        @(negedge clk);
        chk("cfg0_err_pulse", cfg_err, 0);
        start = 1; num_rows = 5;
        @(negedge clk);
        start = 0;
        chk("cfg5_err", cfg_err, 1);
        chk("cfg5_busy", busy, 0);
        @(negedge clk);
        chk("cfg_err_cnt", err_cnt, 2);
        // Start pulse while filling must be ignored.
        start = 1; num_rows = 2; acc_mode = 0;
        @(negedge clk);
        start = 0;
        bus.in_valid = 1; bus.in_data = 4;
        @(negedge clk);
        bus.in_valid = 0; start = 1; num_rows = 3; acc_mode = 1;
        @(negedge clk);
        start = 0; num_rows = 2; acc_mode = 0;
        chk("midfill_cfg_err", cfg_err, 0);
        chk("midfill_in_ready", bus.in_ready, 1);
        bus.in_valid = 1; bus.in_data = 8;
        @(negedge clk);
        bus.in_valid = 0;
        chk("midfill_drain", bus.out_valid, 1);
        chk("midfill_d0", bus.out_data, 4);
        bus.out_ready = 1;
        @(negedge clk);
        chk("midfill_d1", bus.out_data, 8);
        @(negedge clk);
        bus.out_ready = 0;
        chk("midfill_done", done, 1);
        exp_done++;
        @(negedge clk);
        chk("midfill_err_cnt", err_cnt, 2);
        // Clear in IDLE, then accumulate onto zeroed rows.
        clear = 1;
        @(negedge clk);
        clear = 0;
        run_job(mk(1, 1, 3, 0, 0, 0, 3, 0, 0, 0, 0));
        // Reset during DRAIN.
        start = 1; num_rows = 2; acc_mode = 1;
        @(negedge clk);
        start = 0;
        bus.in_valid = 1; bus.in_data = 5;
        @(negedge clk);
        bus.in_data = 6;
        @(negedge clk);
        bus.in_valid = 0;
        chk("rst_mid_drain", bus.out_valid, 1);
        reset = 0;
        #1;
        chk("async_out_valid", bus.out_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_out_data", bus.out_data, 0);
        @(negedge clk);
        reset = 1;
        repeat (3) @(negedge clk);
        chk("rst_no_done", done_cnt, exp_done);
        run_job(mk(2, 1, 5, 6, 0, 0, 5, 6, 0, 0, 0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/acc_sched.md
Name: acc_sched

Overview:
- Sequencing controller for the accumulator buffer at the output of the systolic array.
- Accepts a programmed number of result words from the array's output column and stores each into an addressed row. Each word either overwrites the row or adds into it, for partial-sum accumulation across K tiles.
- Once the programmed row count is filled, drains the rows in order to the unified-buffer write port over a valid/ready handshake.
- Owns the buffer storage, write/read pointers, job FSM and status flags.

Parameters:
- WIDTH, 32, data/accumulator word width in bits.
- DEPTH, 4, number of accumulator rows.
- ADDR_W, 2, pointer width, equal to clog2(DEPTH).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  job start pulse; sampled only in IDLE.
- num_rows  in  ADDR_W+1  rows in job; legal range 1..DEPTH; latched on accepted start.
- acc_mode  in  1  0 = overwrite rows, 1 = add into rows; latched on accepted start.
- clear  in  1  in IDLE, zero all rows next cycle; ignored otherwise.
- in_valid  in  1  array output word valid.
- in_data  in  WIDTH  array output word.
- in_ready  out  1  high only in FILL.
- out_valid  out  1  drain word valid.
- out_data  out  WIDTH  equals mem[rd_ptr] while out_valid; 0 otherwise.
- out_ready  in  1  unified buffer accepts word.
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle pulse at job end.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- overflow  out  1  sticky; cleared by reset or accepted start.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, all rows=0, pointers=0, all outputs 0.
- FSM states: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - start=1 with num_rows in 1..DEPTH: latch num_rows and acc_mode, wr_ptr=0, overflow=0, next state FILL.
  - start=1 with num_rows=0 or num_rows>DEPTH: cfg_err=1 for one cycle; stay IDLE; rows untouched.
  - start and clear together: start wins; clear is ignored.
- FILL:
  - Each cycle with in_valid=1: mem[wr_ptr] <= in_data (acc_mode=0) or mem[wr_ptr] + in_data (acc_mode=1); then wr_ptr increments.
  - A zero-valued in_data is a legal sample and advances wr_ptr.
  - Accumulate mode: the sum wraps mod 2^WIDTH; an unsigned carry-out sets overflow (sticky).
  - The write with wr_ptr == num_rows-1 moves to DRAIN next cycle with rd_ptr=0.
  - Cycles with in_valid=0 hold state.
  - start is ignored.
- DRAIN:
  - out_valid=1, out_data=mem[rd_ptr].
  - On out_valid && out_ready, rd_ptr increments.
  - The handshake with rd_ptr == num_rows-1 moves to DONE.
  - out_ready=0 holds out_data stable.
  - in_valid is ignored (in_ready=0).
- DONE: done=1 for exactly one cycle, then IDLE. Row contents are retained for the next accumulate job.
- Latency:
  - Last FILL write at edge N: out_valid=1 in cycle N+1, showing the updated row 0.
  - Final drain handshake at edge M: done=1 in cycle M+1.
- Rows beyond num_rows are neither written nor drained.
- Pointers never exceed num_rows-1, so there is no wrap within a job.
- Reset asserted mid-FILL or mid-DRAIN: immediate return to the reset state; no done pulse; rows zeroed.

Test Plan:
- Overwrite, 2 rows:
  - Stimulus: reset, start num_rows=2 acc_mode=0, in_data 7 then 9, out_ready=1.
  - Response: out_data 7 then 9; done one cycle after the second handshake; busy low after.
- Accumulate across jobs:
  - Stimulus: job1 overwrite 4 rows {1,2,3,4}; job2 acc_mode=1 with {10,20,30,40}.
  - Response: job2 drains {11,22,33,44}; overflow=0.
- Overflow wrap:
  - Stimulus: overwrite row0 = 0xFFFFFFFF; then accumulate 1 row with in_data=2.
  - Response: out_data=0x00000001; overflow=1, held until the next start.
- Backpressure and zeros:
  - Stimulus: 3-row overwrite {0,5,0} with out_ready toggling 0,1,0,0,1,1.
  - Response: zeros accepted into rows; out_data held while stalled; exactly 3 handshakes; done once.
- Illegal configs and busy start:
  - Stimulus: start num_rows=0, then num_rows=5 (DEPTH=4), then a start pulse mid-FILL of a legal job.
  - Response: cfg_err pulses twice; busy stays 0 for the rejected starts; the mid-FILL start has no effect.
- Clear and reset mid-job:
  - Stimulus: clear in IDLE, then an accumulate job {3}; then reset asserted during DRAIN.
  - Response: out_data=3; after reset, out_valid=0, busy=0, done never pulses, next overwrite-free accumulate yields the input value.
